lc3b_mem_responder: RTL
=======================

Name: lc3b_mem_responder

Overview:
- Memory-side responder for the LC-3b datapath/control memory handshake (mem_read / mem_write / mem_byte_enable / mem_resp).
- Holds a word-organised 16-bit array.
- Accepts one request at a time, waits a programmable latency, commits writes with byte masking, and returns read data with a single-cycle mem_resp pulse.
- Sits between the CPU top level and the testbench/physical memory.

Parameters:
- ADDR_WORDS_LOG2, 10: array depth is 2**ADDR_WORDS_LOG2 16-bit words.
- LATENCY, 3: cycles from the first request cycle to the mem_resp cycle. Legal range 1..15.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst_n  input  1  reset, asynchronous, active-low.
- mem_read  input  1  read request; initiator holds it high until it samples mem_resp.
- mem_write  input  1  write request; same hold rule as mem_read.
- mem_byte_enable  input  2  write mask; bit1 = data[15:8], bit0 = data[7:0].
- mem_address  input  16  byte address.
- mem_wdata  input  16  write data.
- mem_rdata  output  16  read data; valid only in the mem_resp cycle.
- mem_resp  output  1  one-cycle completion pulse.
- proto_err  output  1  sticky protocol-violation flag.

Behaviour:
- Reset (rst_n low, async): state=IDLE, counter=0, mem_resp=0, mem_rdata=16'h0000, proto_err=0.
  - Array contents are not reset.
  - Reset mid-transaction aborts it: no write is committed and no mem_resp is issued.
- Addressing:
  - Word index = mem_address[ADDR_WORDS_LOG2:1].
  - mem_address[0] and upper bits are ignored; out-of-range addresses alias.
- States:
  - IDLE -> BUSY when (mem_read | mem_write) is sampled high.
    - On that edge: capture address, wdata, byte_enable and op.
    - Counter loads LATENCY-1.
    - If LATENCY==1: go directly to RESP.
  - BUSY: counter decrements each cycle; at counter==1 -> RESP.
    - If the request drops (mem_read==0 && mem_write==0) while in BUSY: -> IDLE, abort, no write, no resp.
  - RESP: mem_resp=1 for exactly this cycle.
    - Write: array[idx] bytes with mask bit set take captured wdata; other bytes unchanged. Commit on the edge ending RESP.
    - Read: mem_rdata = array[idx] in this cycle.
    - Next state always IDLE.
- Latency: request first high in cycle 0 gives mem_resp high in cycle LATENCY.
- Back-to-back: initiator changes request on the edge where it sees mem_resp. The next request is sampled in the following cycle, so there is one IDLE cycle between transactions.
- Captured values are used for the whole transaction. Changes to address/wdata/mask during BUSY are ignored; only full deassertion aborts.
- mem_rdata holds its last value outside RESP. After a write response it shows the merged written word.
- Simultaneous mem_read & mem_write in IDLE: proto_err set (sticky until reset). Treated as a write.
- mem_byte_enable==2'b00 on write: no array change; mem_resp still issued.
- Reads ignore mem_byte_enable and return the full word.
- Read-after-write to the same word returns the new data, since the write is committed before the next transaction can reach RESP.

Test Plan:
- LATENCY=3, write 16'hBEEF to address 16'h0010 with mask 2'b11, then read 16'h0010. Required: mem_resp in cycle 3 of each transaction and nowhere else; read mem_rdata=16'hBEEF.
- Preload 16'h1234 at 16'h0020; write 16'hABCD with mask 2'b10, then mask 2'b01 with 16'h00EE, then read. Required: 16'hAB34 after the first write; final read 16'hABEE.
- LATENCY=1, back-to-back reads of 16'h0000 and 16'h0002. Required: each mem_resp arrives 1 cycle after its request; exactly one IDLE gap; no duplicate pulses.
- Write request dropped after 1 cycle of BUSY, then read the same address. Required: no mem_resp for the dropped write; read returns the old value.
- mem_read and mem_write asserted together with 16'h5555 to 16'h0040. Required: proto_err=1 and remains set; readback 16'h5555.
- rst_n pulsed low mid-BUSY on a write of 16'hFFFF. Required: all outputs 0 immediately (async); readback shows the pre-write value; no mem_resp pulse.

Source files
------------

// File: rtl/lc3b_mem_responder.sv
// Memory-side responder for the LC-3b mem_read/mem_write/mem_resp handshake.
// Word-organised 16-bit array, programmable latency, byte-masked writes.
module lc3b_mem_responder #(
    parameter int ADDR_WORDS_LOG2 = 10,
    parameter int LATENCY         = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_byte_enable,
    input  logic [15:0] mem_address,
    input  logic [15:0] mem_wdata,
    output logic [15:0] mem_rdata,
    output logic        mem_resp,
    output logic        proto_err
);

    localparam int DEPTH = 1 << ADDR_WORDS_LOG2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP
    } state_t;

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic [3:0]                   r_cnt;
    logic [3:0]                   w_cnt_nxt;
    logic [ADDR_WORDS_LOG2-1:0]   r_idx;
    logic [15:0]                  r_wdata;
    logic [1:0]                   r_be;
    logic                         r_wr;
    logic                         r_proto;
    logic [15:0]                  r_rdata;
    logic [15:0]                  r_mem [DEPTH];

    logic                         w_req;
    logic                         w_capture;
    logic [15:0]                  w_old;
    logic [15:0]                  w_merged;
    logic [15:0]                  w_word;
    logic                         w_unused;

    assign w_req    = mem_read | mem_write;
    assign w_unused = ^{mem_address[15:ADDR_WORDS_LOG2+1], mem_address[0]};

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_capture   = 1'b1;
                    w_cnt_nxt   = 4'(LATENCY - 1);
                    w_state_nxt = (LATENCY == 1) ? S_RESP : S_BUSY;
                end
            end
            S_BUSY: begin
                // Full deassertion aborts even on the cycle that would enter RESP.
                if (!w_req) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == 4'd1) begin
                    w_state_nxt = S_RESP;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt - 4'd1;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_old    = r_mem[r_idx];
    assign w_merged = {r_be[1] ? r_wdata[15:8] : w_old[15:8],
                       r_be[0] ? r_wdata[7:0]  : w_old[7:0]};
    assign w_word   = r_wr ? w_merged : w_old;

    assign mem_resp  = (r_state == S_RESP);
    assign mem_rdata = mem_resp ? w_word : r_rdata;
    assign proto_err = r_proto;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_wr    <= 1'b0;
            r_proto <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_capture) begin
                r_idx   <= mem_address[ADDR_WORDS_LOG2:1];
                r_wdata <= mem_wdata;
                r_be    <= mem_byte_enable;
                r_wr    <= mem_write;
                if (mem_read && mem_write) begin
                    r_proto <= 1'b1;
                end
            end
            if (r_state == S_RESP) begin
                r_rdata <= w_word;
            end
        end
    end

    // Array is not reset; a reset during RESP forces IDLE first, so nothing commits.
    always_ff @(posedge clk) begin
        if (rst_n && (r_state == S_RESP) && r_wr) begin
            r_mem[r_idx] <= w_merged;
        end
    end

endmodule
